// File: rtl/commit_stream_cmp.sv
// commit_stream_cmp - lockstep commit comparator.
//
// Buffers up to NRET retired instructions per cycle from the DUT (d_*) and
// from the reference model (r_*) in two independent FIFOs, then compares
// head pairs in program order, up to NRET pairs per cycle. The first
// divergent pair is latched (sequence number and per-field mask) and the
// comparator freezes until rst, leaving that pair at both FIFO heads.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   {d,r}_valid         per-lane valid, lane 0 oldest, contiguous from lane 0
//   {d,r}_pc/_rd_data/_mem_addr/_mem_wdata   lane-packed XLEN fields
//   {d,r}_instr/_rd_addr/_priv               lane-packed 32/5/2-bit fields
//   {d,r}_mem_we/_trap  per-lane flags
//   d_ready, r_ready    side FIFO has at least NRET free slots
//   mismatch            sticky first-divergence flag
//   mism_seq            0-based commit index of the first divergent pair
//   mism_field          {priv,trap,mem_wdata,mem_addr,mem_we,rd_data,rd_addr,instr,pc}
//   overflow            sticky {ref,dut}: lanes presented while ready was low
//   match_cnt           number of pairs compared equal (wraps)
//   timeout             sticky watchdog flag
//
// Optional feature: define COMMIT_CMP_TIMEOUT_EN to build the watchdog that
// flags one side committing while the other stays silent for TIMEOUT cycles.
// Without it, timeout is tied low.

module commit_stream_cmp #(
    parameter int XLEN    = 64,
    parameter int NRET    = 2,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRET-1:0]      d_valid,
    input  logic [NRET*XLEN-1:0] d_pc,
    input  logic [NRET*32-1:0]   d_instr,
    input  logic [NRET*5-1:0]    d_rd_addr,
    input  logic [NRET*XLEN-1:0] d_rd_data,
    input  logic [NRET-1:0]      d_mem_we,
    input  logic [NRET*XLEN-1:0] d_mem_addr,
    input  logic [NRET*XLEN-1:0] d_mem_wdata,
    input  logic [NRET-1:0]      d_trap,
    input  logic [NRET*2-1:0]    d_priv,
    input  logic [NRET-1:0]      r_valid,
    input  logic [NRET*XLEN-1:0] r_pc,
    input  logic [NRET*32-1:0]   r_instr,
    input  logic [NRET*5-1:0]    r_rd_addr,
    input  logic [NRET*XLEN-1:0] r_rd_data,
    input  logic [NRET-1:0]      r_mem_we,
    input  logic [NRET*XLEN-1:0] r_mem_addr,
    input  logic [NRET*XLEN-1:0] r_mem_wdata,
    input  logic [NRET-1:0]      r_trap,
    input  logic [NRET*2-1:0]    r_priv,
    output logic                 d_ready,
    output logic                 r_ready,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     mism_seq,
    output logic [8:0]           mism_field,
    output logic [1:0]           overflow,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [1:0]      priv;
        logic            trap;
        logic [XLEN-1:0] mem_wdata;
        logic [XLEN-1:0] mem_addr;
        logic            mem_we;
        logic [XLEN-1:0] rd_data;
        logic [4:0]      rd_addr;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic {RUN, FROZEN} state_t;

    // rd_data only matters when a register is written; memory payload only
    // matters on a store. Qualifiers come from the DUT side.
    function automatic logic [8:0] field_diff(input entry_t d, input entry_t r);
        logic [8:0] m;
        m[0] = (d.pc != r.pc);
        m[1] = (d.instr != r.instr);
        m[2] = (d.rd_addr != r.rd_addr);
        m[3] = (d.rd_addr != 5'd0) && (d.rd_data != r.rd_data);
        m[4] = (d.mem_we != r.mem_we);
        m[5] = d.mem_we && (d.mem_addr != r.mem_addr);
        m[6] = d.mem_we && (d.mem_wdata != r.mem_wdata);
        m[7] = (d.trap != r.trap);
        m[8] = (d.priv != r.priv);
        return m;
    endfunction

    function automatic logic [PW-1:0] popcnt(input logic [NRET-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < NRET; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   d_wptr_q, d_wptr_d, d_rptr_q, d_rptr_d;
    logic [PW-1:0]   r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
    logic            d_ready_q, d_ready_d, r_ready_q, r_ready_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d, mism_seq_q, mism_seq_d;
    logic [8:0]      mism_field_q, mism_field_d;
    logic [1:0]      overflow_q, overflow_d;

    entry_t          d_mem [DEPTH];
    entry_t          r_mem [DEPTH];
    entry_t          d_in [NRET];
    entry_t          r_in [NRET];
    entry_t          d_head [NRET];
    entry_t          r_head [NRET];
    logic [AW-1:0]   d_waddr [NRET];
    logic [AW-1:0]   r_waddr [NRET];
    logic [8:0]      pair_mask [NRET];
    logic [PW-1:0]   d_cnt, r_cnt, k, pop_n, pop_eff, d_push_n, r_push_n;
    logic            hit;
    logic [8:0]      hit_mask;

    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            d_in[i].pc        = d_pc[i*XLEN +: XLEN];
            d_in[i].instr     = d_instr[i*32 +: 32];
            d_in[i].rd_addr   = d_rd_addr[i*5 +: 5];
            d_in[i].rd_data   = d_rd_data[i*XLEN +: XLEN];
            d_in[i].mem_we    = d_mem_we[i];
            d_in[i].mem_addr  = d_mem_addr[i*XLEN +: XLEN];
            d_in[i].mem_wdata = d_mem_wdata[i*XLEN +: XLEN];
            d_in[i].trap      = d_trap[i];
            d_in[i].priv      = d_priv[i*2 +: 2];
            r_in[i].pc        = r_pc[i*XLEN +: XLEN];
            r_in[i].instr     = r_instr[i*32 +: 32];
            r_in[i].rd_addr   = r_rd_addr[i*5 +: 5];
            r_in[i].rd_data   = r_rd_data[i*XLEN +: XLEN];
            r_in[i].mem_we    = r_mem_we[i];
            r_in[i].mem_addr  = r_mem_addr[i*XLEN +: XLEN];
            r_in[i].mem_wdata = r_mem_wdata[i*XLEN +: XLEN];
            r_in[i].trap      = r_trap[i];
            r_in[i].priv      = r_priv[i*2 +: 2];
            d_waddr[i]        = AW'(d_wptr_q + PW'(i));
            r_waddr[i]        = AW'(r_wptr_q + PW'(i));
            d_head[i]         = d_mem[AW'(d_rptr_q + PW'(i))];
            r_head[i]         = r_mem[AW'(r_rptr_q + PW'(i))];
            pair_mask[i]      = field_diff(d_head[i], r_head[i]);
        end
    end

    // Find the first unequal pair among the k examined; pop_n counts the
    // equal pairs in front of it.
    always_comb begin
        d_cnt    = d_wptr_q - d_rptr_q;
        r_cnt    = r_wptr_q - r_rptr_q;
        k        = (d_cnt < r_cnt) ? d_cnt : r_cnt;
        if (k > PW'(NRET)) k = PW'(NRET);
        hit      = 1'b0;
        hit_mask = '0;
        pop_n    = '0;
        for (int i = 0; i < NRET; i++) begin
            if (!hit && (PW'(i) < k)) begin
                if (pair_mask[i] != '0) begin
                    hit      = 1'b1;
                    hit_mask = pair_mask[i];
                end else begin
                    pop_n = pop_n + PW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pop_eff      = '0;
        match_cnt_d  = match_cnt_q;
        mism_seq_d   = mism_seq_q;
        mism_field_d = mism_field_q;
        if (state_q == RUN) begin
            pop_eff     = pop_n;
            match_cnt_d = match_cnt_q + CNT_W'(pop_n);
            if (hit) begin
                state_d      = FROZEN;
                mism_seq_d   = match_cnt_q + CNT_W'(pop_n);
                mism_field_d = hit_mask;
            end
        end
        // ready guarantees NRET free slots, so an accepted write always fits.
        d_push_n   = d_ready_q ? popcnt(d_valid) : '0;
        r_push_n   = r_ready_q ? popcnt(r_valid) : '0;
        overflow_d = overflow_q | {(!r_ready_q && (|r_valid)), (!d_ready_q && (|d_valid))};
        d_wptr_d   = d_wptr_q + d_push_n;
        r_wptr_d   = r_wptr_q + r_push_n;
        d_rptr_d   = d_rptr_q + pop_eff;
        r_rptr_d   = r_rptr_q + pop_eff;
        d_ready_d  = (PW'(DEPTH) - (d_wptr_d - d_rptr_d)) >= PW'(NRET);
        r_ready_d  = (PW'(DEPTH) - (r_wptr_d - r_rptr_d)) >= PW'(NRET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            d_wptr_q     <= '0;
            d_rptr_q     <= '0;
            r_wptr_q     <= '0;
            r_rptr_q     <= '0;
            d_ready_q    <= 1'b1;
            r_ready_q    <= 1'b1;
            match_cnt_q  <= '0;
            mism_seq_q   <= '0;
            mism_field_q <= '0;
            overflow_q   <= '0;
        end else begin
            state_q      <= state_d;
            d_wptr_q     <= d_wptr_d;
            d_rptr_q     <= d_rptr_d;
            r_wptr_q     <= r_wptr_d;
            r_rptr_q     <= r_rptr_d;
            d_ready_q    <= d_ready_d;
            r_ready_q    <= r_ready_d;
            match_cnt_q  <= match_cnt_d;
            mism_seq_q   <= mism_seq_d;
            mism_field_q <= mism_field_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRET; i++) begin
            if (d_ready_q && d_valid[i]) d_mem[d_waddr[i]] <= d_in[i];
            if (r_ready_q && r_valid[i]) r_mem[r_waddr[i]] <= r_in[i];
        end
    end

    assign d_ready    = d_ready_q;
    assign r_ready    = r_ready_q;
    assign mismatch   = (state_q == FROZEN);
    assign mism_seq   = mism_seq_q;
    assign mism_field = mism_field_q;
    assign overflow   = overflow_q;
    assign match_cnt  = match_cnt_q;

`ifdef COMMIT_CMP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_q, timeout_d;

    // Counts cycles in which exactly one side has pending commits; holds
    // while frozen and saturates at TIMEOUT.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if ((d_cnt != '0) == (r_cnt != '0)) begin
            wd_cnt_d = '0;
        end else if ((state_q == RUN) && (wd_cnt_q != TW'(TIMEOUT))) begin
            wd_cnt_d = wd_cnt_q + TW'(1);
        end
        if (wd_cnt_d == TW'(TIMEOUT)) timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout        = 1'b0;
`endif

endmodule

// File: doc/commit_stream_cmp.md
# commit_stream_cmp

Lockstep commit comparator for the ISA-compliance bench. It accepts up to NRET retired instructions per cycle from the DUT commit channel and up to NRET from the reference model. Each stream is buffered in its own FIFO, and entries are compared in program order at up to NRET pairs per cycle. The first divergence is latched with its sequence number and a per-field mismatch mask; the pipeline then freezes for debug. It sits between the DUT/REF commit taps and the scoreboard/status CSRs, and supersedes the single-lane, assertion-only commit channel.

## Interface
- XLEN, 64, width of pc/rd_data/mem_addr/mem_wdata
- NRET, 2, commit lanes per side per cycle (1..4)
- DEPTH, 16, entries per side FIFO (power of 2, ≥ 2·NRET)
- CNT_W, 32, width of match counter and sequence numbers
- TIMEOUT, 1024, watchdog limit in cycles (used only with COMMIT_CMP_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  reset; one clock, reset synchronous active-high
- {d,r}_valid  in  NRET  per-lane valid (d = DUT, r = REF); lane 0 oldest; valid lanes contiguous from lane 0
- {d,r}_pc, _rd_data, _mem_addr, _mem_wdata  in  NRET·XLEN  lane-packed, lane i at [i·XLEN +: XLEN]
- {d,r}_instr  in  NRET·32;  {d,r}_rd_addr  in  NRET·5;  {d,r}_priv  in  NRET·2
- {d,r}_mem_we, {d,r}_trap  in  NRET  per-lane flags
- d_ready, r_ready  out  1  high when the side FIFO has ≥ NRET free slots
- mismatch  out  1  sticky first-divergence flag
- mism_seq  out  CNT_W  0-based commit index of the first divergent pair
- mism_field  out  9  {priv,trap,mem_wdata,mem_addr,mem_we,rd_data,rd_addr,instr,pc}, bit 0 = pc
- overflow  out  2  sticky {ref,dut}: valid lanes presented while ready was low
- match_cnt  out  CNT_W  pairs compared equal
- timeout  out  1  sticky watchdog flag (constant 0 when the macro is off)

## Operation
- Write: on each edge with x_ready=1, the valid lanes are pushed in lane order. Count = popcount(x_valid).
- Write while x_ready=0: the lanes are dropped and overflow[side] is set. The FIFO and its pointers are unchanged.
- Compare: k = min(d_count, r_count, NRET) head pairs are examined combinationally each cycle.
- Fields always compared: pc, instr, rd_addr, mem_we, trap, priv.
- rd_data is compared only when the DUT rd_addr≠0. mem_addr and mem_wdata are compared only when DUT mem_we=1.
- Let j = index of the first unequal pair among the k examined (j = k if none).
- On the edge: pop j entries from both FIFOs and add j to match_cnt.
- If j<k: set mismatch, latch mism_seq = match_cnt_old + j, latch the mism_field mask of pair j.
- Frozen state (mismatch=1): no pops, no counter updates, mism_* held. Writes continue until the FIFOs fill, then the ready outputs drop.
- The mismatching pair remains at both FIFO heads for debug readback.
- States: RUN → FROZEN on the first mismatch. FROZEN → RUN only through rst.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = count==DEPTH.
- match_cnt wraps modulo 2^CNT_W with no flag.

## Timing
- Reset values: all FIFOs empty; d_ready=r_ready=1; mismatch=0; mism_seq=0; mism_field=0; overflow=0; match_cnt=0; timeout=0.
- Latency: a pair written at edge N (both sides) is compared during cycle N+1. match_cnt or mismatch reflect it after edge N+1.
- No combinational path from inputs to any output.
- Ready is registered from the pre-edge count. It reflects the pushes and pops of the previous edge.
- Push and pop on the same edge are legal at any occupancy, including full and empty.
- rst asserted mid-stream discards all FIFO contents and clears every output at the next edge.

## Configuration
- COMMIT_CMP_TIMEOUT_EN defined:
  - A cycle counter runs while exactly one FIFO is non-empty and the machine is not frozen.
  - The counter clears whenever both FIFOs are non-empty or both are empty.
  - When the count reaches TIMEOUT, timeout is set (sticky until rst).
- Not defined: no counter logic; timeout is tied to 0.

## Test plan
- Identical streams, NRET=2, 100 cycles × 2 lanes per side -> match_cnt=200, mismatch=0, no overflow, both FIFOs empty 2 cycles after the last write.
- DUT commit #37 has rd_data=0x5 vs REF 0x6 with rd_addr=3 -> mismatch=1, mism_seq=37, mism_field=0x008, match_cnt=37 and frozen thereafter.
- Same rd_data difference with rd_addr=0; mem_wdata difference with mem_we=0 on both sides -> no mismatch.
- DUT sends 20 commits before REF starts, DEPTH=16 -> d_ready falls after 16 entries; the 17th push sets overflow=2'b01; other flags unchanged.
- Reset pulse while both FIFOs hold 5 entries -> next cycle: counts 0, match_cnt=0, mismatch=0, ready=1.
- With COMMIT_CMP_TIMEOUT_EN and TIMEOUT=8: one DUT commit, REF silent -> timeout=1 exactly 8 cycles after the entry lands; without the macro, timeout stays 0.
